div_datapath: RTL and testbench

Sequential 32-bit integer divider datapath for the MIPS-style pipeline's HI/LO unit. It accepts a DIV or DIVU request from the execute stage and runs one restoring shift-subtract iteration per clock for WIDTH cycles. It then sign-corrects the result, writes quotient to LO and remainder to HI, and pulses `done` so the multicycle stall logic can release the pipeline. It sits directly downstream of the divide-control sequencer and directly upstream of the HI/LO register write port.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 23 ++
 rtl/div_datapath.sv | 95 +++++++++
 tb/tb_div_datapath.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the HI/LO divide unit.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH);

  localparam logic [5:0] FUNCT_DIV  = 6'd26;
  localparam logic [5:0] FUNCT_DIVU = 6'd27;

  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // The shifted remainder needs WIDTH+1 bits so a set top bit still compares correctly.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = (shifted >= {1'b0, dvs});
  assign rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx  = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/div_datapath.sv
// Sequential DIV/DIVU unit: magnitudes are divided by a restoring loop,
// then sign-corrected into LO (quotient) and HI (remainder).
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             dn_neg;
  logic             dv_neg;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             accept;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;

  assign is_signed = (funct == FUNCT_DIV);
  assign accept    = start && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));
  assign a_neg     = is_signed && dividend[WIDTH-1];
  assign b_neg     = is_signed && divisor[WIDTH-1];
  assign busy      = (state != IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .quo    (quo),
    .dvs    (dvs),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      dn_neg      <= 1'b0;
      dv_neg      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dn_neg <= a_neg;
            dv_neg <= b_neg;
            quo    <= a_neg ? -dividend : dividend;
            dvs    <= b_neg ? -divisor : divisor;
            rem    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          rem   <= rem_nx;
          quo   <= quo_nx;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // Remainder takes the dividend's sign, matching truncating division.
          lo          <= (dn_neg ^ dv_neg) ? -quo : quo;
          hi          <= dn_neg ? -rem : rem;
          div_by_zero <= (dvs == '0);
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_datapath.sv
// Randomized scoreboard bench for div_datapath against a plain-arithmetic
// reference of MIPS DIV/DIVU semantics.
module tb_div_datapath;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          acceptCycle;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   failCount  = 0;
  int   doneCount  = 0;
  int   cycle      = 0;

  div_datapath #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .funct       (funct),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Truncating division on 64-bit integers; divide by zero gives all-ones magnitude and |dividend|.
  task automatic refDiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, sq, sr;
    if (f == FUNCT_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    z = (b == 32'd0);
    if (z) begin
      sq = (sa < 0) ? 64'sd1 : -64'sd1;
      if (f == FUNCT_DIVU) sq = longint'(32'hFFFFFFFF);
      sr = sa;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
    end
    q = sq[31:0];
    r = sr[31:0];
  endtask

  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start    = 1'b1;
    funct    = f;
    dividend = a;
    divisor  = b;
    if (f == FUNCT_DIV || f == FUNCT_DIVU) begin
      refDiv(f, a, b, e.lo, e.hi, e.dbz);
      e.acceptCycle = cycle + 1;
      sbQ.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int busyN);
    bit seen = 0;
    busyN = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busyN++;
    end
    if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic runOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int busyN;
    applyStimulus(f, a, b);
    waitDone(busyN);
    checkOutput("busyCycles", busyN, 32'd33);
    checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("lo", lo, e.lo);
        checkOutput("hi", hi, e.hi);
        checkOutput("divByZero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkOutput("latency", cycle - e.acceptCycle, 32'd33);
      end
    end
  end

  initial begin
    int busyN;
    int d0;
    logic [5:0]  f;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; funct = 6'd0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstHi", hi, 32'd0);
    checkOutput("rstLo", lo, 32'd0);
    checkOutput("rstDbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp(FUNCT_DIVU, 32'd100, 32'd7);
    runOp(FUNCT_DIV, -32'sd100, 32'd7);
    runOp(FUNCT_DIV, 32'd100, -32'sd7);
    runOp(FUNCT_DIVU, 32'h12345678, 32'd0);
    runOp(FUNCT_DIVU, 32'd9, 32'd3);
    runOp(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    runOp(FUNCT_DIV, -32'sd77, 32'd0);

    // Invalid funct must not start anything.
    @(negedge clk);
    d0 = doneCount;
    start = 1'b1; funct = 6'd24; dividend = 32'd40; divisor = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("badFunctBusy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("badFunctNoDone", doneCount - d0, 32'd0);

    // Start while busy is ignored.
    d0 = doneCount;
    applyStimulus(FUNCT_DIVU, 32'd50, 32'd5);
    repeat (10) @(negedge clk);
    start = 1'b1; funct = FUNCT_DIVU; dividend = 32'd999; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone(busyN);
    repeat (40) @(negedge clk);
    checkOutput("singleDone", doneCount - d0, 32'd1);

    // Reset mid-operation aborts with no done.
    applyStimulus(FUNCT_DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortHi", hi, 32'd0);
    checkOutput("abortLo", lo, 32'd0);
    sbQ.delete();
    d0 = doneCount;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abortNoDone", doneCount - d0, 32'd0);
    runOp(FUNCT_DIVU, 32'd7, 32'd2);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 25; i++) begin
      f = ($urandom_range(0, 1) == 0) ? FUNCT_DIV : FUNCT_DIVU;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      runOp(f, a, b);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
